// File: rtl/divisor_4bits.sv
// divisor_4bits: sequential unsigned restoring divider, one quotient bit per clock.
// Q = A / B and R = A mod B, with a start/busy/done handshake for the ALU's
// multi-cycle divide slot. Each trial subtraction is a (WIDTH+1)-bit ripple add
// of P + ~B + 1 built from 1-bit full-adder cells; carry-out = 1 means no borrow.
// Optional feature: define DIV_ZERO_DETECT_EN to short-circuit B = 0 to a
// one-cycle result with the div_zero flag raised. Without it, B = 0 runs the
// normal iterations (Q = all ones, R = A) and div_zero is tied low.

// 1-bit full-adder cell, same cell the ripple-carry adder is built from.
module divisor_4bits_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module divisor_4bits #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] aq;      // dividend shifting out, quotient bits shifting in
    logic [WIDTH-1:0] bq;      // captured divisor
    logic [WIDTH-1:0] p;       // partial remainder
    logic [CW-1:0]    count;   // iterations left

    logic             accept;
    logic             b_zero;

    // Shifted {P, Aq}: P picks up the dividend MSB. P never exceeds the dividend
    // bits already shifted in, so it always fits in WIDTH bits after the shift.
    logic [WIDTH-1:0] p_sh;
    logic [WIDTH-1:0] aq_sh;
    assign p_sh  = {p[WIDTH-2:0], aq[WIDTH-1]};
    assign aq_sh = {aq[WIDTH-2:0], 1'b0};

    // Trial subtraction T = {0,P} - {0,B} as {0,P} + ~{0,B} + 1 on a full-adder chain.
    logic [WIDTH:0]   op_a;
    logic [WIDTH:0]   op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] carry;
    logic             no_borrow;

    assign op_a     = {1'b0, p_sh};
    assign op_b     = ~{1'b0, bq};
    assign carry[0] = 1'b1;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
        divisor_4bits_fa u_fa (
            .a   (op_a[i]),
            .b   (op_b[i]),
            .cin (carry[i]),
            .s   (sum[i]),
            .cout(carry[i+1])
        );
    end

    // Carry-out set and a clear sign bit of T both say T >= 0; they always agree.
    assign no_borrow = carry[WIDTH+1] & ~sum[WIDTH];

    // A start is taken whenever the unit is not iterating (idle or result cycle).
    assign accept = start && ((state == OCIOSO) || (state == FIM));

`ifdef DIV_ZERO_DETECT_EN
    assign b_zero = (B == '0);
`else
    assign b_zero = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OCIOSO;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and busy.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            OCIOSO: begin
                if (start) begin
                    state_next = b_zero ? FIM : CALCULA;
                end
            end
            CALCULA: begin
                busy = 1'b1;
                if (count == CW'(1)) begin
                    state_next = FIM;
                end
            end
            FIM: begin
                if (start) begin
                    state_next = b_zero ? FIM : CALCULA;
                end else begin
                    state_next = OCIOSO;
                end
            end
            default: state_next = OCIOSO;
        endcase
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            aq    <= '0;
            bq    <= '0;
            p     <= '0;
            count <= '0;
            Q     <= '0;
            R     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == CALCULA) begin
                aq    <= {aq_sh[WIDTH-1:1], no_borrow};
                p     <= no_borrow ? sum[WIDTH-1:0] : p_sh;
                count <= count - CW'(1);
            end
            if (state == FIM) begin
                Q    <= aq;
                R    <= p;
                done <= 1'b1;
            end
            // A start in the result cycle loads the next operation while the
            // previous result is still being published above.
            if (accept) begin
                bq    <= B;
                count <= CW'(WIDTH);
                if (b_zero) begin
                    aq <= '1;
                    p  <= A;
                end else begin
                    aq <= A;
                    p  <= '0;
                end
            end
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    logic dz_q;

    // Divide-by-zero flag: remembered at start, published with the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            dz_q     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            if (accept) begin
                dz_q <= b_zero;
            end
            if (state == FIM) begin
                div_zero <= dz_q;
            end else if (accept) begin
                div_zero <= 1'b0;
            end
        end
    end
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divisor_4bits.sv
// tb_divisor_4bits: randomized bench for divisor_4bits with a behavioural
// reference model (plain / and %, cycle-indexed result schedule).
// Honours DIV_ZERO_DETECT_EN when the build defines it.
module tb_divisor_4bits;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         busy;
    logic         done;
    logic         div_zero;

    divisor_4bits #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .Q       (Q),
        .R       (R),
        .busy    (busy),
        .done    (done),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           done_at;
        int           lat;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t         pend[$];
    int           edge_idx = 0;
    int           free_at  = 0;
    logic [W-1:0] last_q   = '0;
    logic [W-1:0] last_r   = '0;
    logic         last_dz  = 1'b0;
    logic         exp_done = 1'b0;
    logic         exp_busy = 1'b0;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_idx);
        end
    endtask

    // Reference model for one rising edge, from the inputs the DUT samples.
    task automatic model_edge();
        exp_t e;
        logic acc;
        int   a_i, b_i;
        exp_done = 1'b0;
        if (rst) begin
            pend.delete();
            last_q  = '0;
            last_r  = '0;
            last_dz = 1'b0;
            free_at = edge_idx + 1;
        end else begin
            acc = start && (edge_idx >= free_at);
            if (acc) last_dz = 1'b0;
            if (pend.size() > 0 && pend[0].done_at == edge_idx) begin
                e        = pend.pop_front();
                exp_done = 1'b1;
                last_q   = e.q;
                last_r   = e.r;
                last_dz  = e.dz;
            end
            if (acc) begin
                a_i = int'(A);
                b_i = int'(B);
                if (b_i == 0) begin
                    e.q = '1;
                    e.r = A;
                end else begin
                    e.q = W'(a_i / b_i);
                    e.r = W'(a_i % b_i);
                end
                e.dz      = DZ && (b_i == 0);
                e.lat     = e.dz ? 1 : W + 1;
                e.done_at = edge_idx + e.lat;
                pend.push_back(e);
                free_at = edge_idx + e.lat;
            end
        end
        exp_busy = 1'b0;
        foreach (pend[i]) begin
            if (pend[i].lat > 1 && edge_idx <= pend[i].done_at - 2) exp_busy = 1'b1;
        end
        edge_idx++;
    endtask

    // One clock: model the edge, then compare every output mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("done", done, exp_done);
        check("busy", busy, exp_busy);
        check("Q", Q, last_q);
        check("R", R, last_r);
        check("div_zero", div_zero, last_dz);
    endtask

    // Wait until the unit would take a start, then pulse start with a/b.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard = 0;
        while (edge_idx < free_at && guard < 40) begin
            tick();
            guard++;
        end
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Let the pending result come out, scribbling on A/B meanwhile.
    task automatic drain();
        int guard;
        guard = 0;
        while (pend.size() > 0 && guard < 40) begin
            A = W'($urandom);
            B = W'($urandom);
            tick();
            guard++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic operation.
        issue(4'd13, 4'd3);
        drain();
        tick();

        // Back-to-back: second start lands in the result cycle of the first.
        issue(4'd15, 4'd1);
        issue(4'd2, 4'd7);
        drain();
        tick();

        // Divide by zero.
        issue(4'd9, 4'd0);
        drain();
        tick();

        // Start while busy is ignored.
        issue(4'd12, 4'd5);
        tick();
        A     = 4'd1;
        B     = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        drain();
        tick();

        // Reset on the third iteration cycle aborts the division.
        issue(4'd14, 4'd3);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        issue(4'd7, 4'd2);
        drain();
        tick();

        // Exhaustive sweep, including B = 0.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(W'(a), W'(b));
                drain();
            end
        end

        // Random operations with noisy starts while busy and random gaps.
        for (int n = 0; n < 300; n++) begin
            issue(W'($urandom), ($urandom_range(0, 7) == 0) ? 4'd0 : W'($urandom));
            while (edge_idx < free_at) begin
                start = 1'($urandom_range(0, 1));
                A     = W'($urandom);
                B     = W'($urandom);
                tick();
            end
            start = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
